// File: rtl/argmax_out.sv
// argmax_out: sequential argmax over a vector of signed class scores.
// Takes one packed score vector over a valid/ready handshake and scans it one
// element per cycle. It returns the index and value of the largest score over a
// second valid/ready handshake. When scores tie, the lowest index wins.
module argmax_out #(
    parameter int unsigned INPUT_WIDTH = 32,
    parameter int unsigned INPUT_NUM   = 10,
    parameter int unsigned IDX_WIDTH   = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [INPUT_WIDTH*INPUT_NUM-1:0] data_in,
    input  logic                             data_in_vaild,
    output logic                             data_in_ready,
    output logic [IDX_WIDTH-1:0]             class_out,
    output logic [INPUT_WIDTH-1:0]           max_out,
    output logic                             data_out_vaild,
    input  logic                             data_out_ready
);

    localparam int unsigned LAST_IDX = INPUT_NUM - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                         state;
    logic signed [INPUT_WIDTH-1:0]  elem_q [INPUT_NUM];
    logic signed [INPUT_WIDTH-1:0]  run_max;
    logic        [IDX_WIDTH-1:0]    run_idx;
    logic        [IDX_WIDTH-1:0]    cnt;

    logic signed [INPUT_WIDTH-1:0]  cur_elem;
    logic                           cand_gt;
    logic signed [INPUT_WIDTH-1:0]  nxt_max;
    logic        [IDX_WIDTH-1:0]    nxt_idx;

    // Compare the element under the counter with the running max. A strict
    // greater-than keeps the earlier index when scores tie.
    always_comb begin
        cur_elem = '0;
        cand_gt  = 1'b0;
        nxt_max  = run_max;
        nxt_idx  = run_idx;
        cur_elem = elem_q[cnt];
        cand_gt  = ($signed(cur_elem) > $signed(run_max));
        if (cand_gt) begin
            nxt_max = cur_elem;
            nxt_idx = cnt;
        end
    end

    // Control FSM, vector capture, running max and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            data_in_ready  <= 1'b0;
            data_out_vaild <= 1'b0;
            class_out      <= '0;
            max_out        <= '0;
            run_max        <= '0;
            run_idx        <= '0;
            cnt            <= '0;
            for (int i = 0; i < int'(INPUT_NUM); i++) begin
                elem_q[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (data_in_ready && data_in_vaild) begin
                        for (int i = 0; i < int'(INPUT_NUM); i++) begin
                            elem_q[i] <= data_in[i*INPUT_WIDTH +: INPUT_WIDTH];
                        end
                        run_max       <= data_in[INPUT_WIDTH-1:0];
                        run_idx       <= '0;
                        cnt           <= IDX_WIDTH'(1);
                        data_in_ready <= 1'b0;
                        state         <= (INPUT_NUM > 1) ? SCAN : DONE;
                    end else begin
                        data_in_ready <= 1'b1;
                    end
                end

                SCAN: begin
                    run_max <= nxt_max;
                    run_idx <= nxt_idx;
                    if (cnt == IDX_WIDTH'(LAST_IDX)) begin
                        class_out      <= nxt_idx;
                        max_out        <= nxt_max;
                        data_out_vaild <= 1'b1;
                        state          <= DONE;
                    end else begin
                        cnt <= cnt + IDX_WIDTH'(1);
                    end
                end

                DONE: begin
                    // A single-element vector arrives here without a scan, so the
                    // result is published one edge after acceptance.
                    if (!data_out_vaild) begin
                        class_out      <= run_idx;
                        max_out        <= run_max;
                        data_out_vaild <= 1'b1;
                    end else if (data_out_ready) begin
                        data_out_vaild <= 1'b0;
                        data_in_ready  <= 1'b1;
                        state          <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
